// File: rtl/tx_serial_7e1.sv
// ---------------------------------------------------------------------------
// tx_serial_7e1 -- asynchronous serial transmitter, 7 data bits, even parity,
// 1 stop bit.
//
// A start request in IDLE captures the character and sends a 10-bit frame,
// LSB first:
//   start(0), d[0]..d[6], parity, stop(1)
// Each bit is held for M clocks. One DONE cycle follows the frame, then the
// block returns to IDLE.
//
// Parameters
//   M            clock cycles per bit (2..8191, default 434 = 50 MHz/115200)
//
// Ports
//   clock        system clock; all state changes on its rising edge
//   reset        synchronous, active-low
//   partida      start request; sampled only in IDLE
//   dados_ascii  7-bit character, captured when a start request is accepted
//   saida_serial serial line, driven from a flop, idles high
//   ocupado      high for the 10*M cycles of a frame
//   pronto       one-clock pulse after the stop bit completes
//   db_estado    debug state code (0 IDLE, 1 TRANSMIT, 2 DONE, F illegal)
// ---------------------------------------------------------------------------
module tx_serial_7e1 #(
  parameter int M = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [6:0] dados_ascii,
  output logic       saida_serial,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int          TW       = (M > 1) ? $clog2(M) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(M - 1);
  localparam logic [3:0]  LAST_BIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    TRANSMIT = 2'b01,
    DONE     = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [TW-1:0]   r_tick;
  logic [3:0]      r_bit;
  logic [9:0]      r_shift;
  logic            r_saida;

  logic            w_load;
  logic            w_tick_end;
  logic            w_last_bit;
  logic [9:0]      w_frame;

  // Frame is assembled so bit 0 is the first to go out on the line.
  assign w_frame    = {1'b1, ^dados_ascii, dados_ascii, 1'b0};
  assign w_tick_end = (r_tick == TICK_MAX);
  assign w_last_bit = (r_bit == LAST_BIT);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // -------------------------------------------------------------------------
  // Next state and status outputs. Outputs decode the state flop only, so
  // none of them has a combinational path from an input.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    ocupado     = 1'b0;
    pronto      = 1'b0;
    db_estado   = 4'h0;
    case (r_state)
      IDLE: begin
        db_estado = 4'h0;
        if (partida) begin
          w_load      = 1'b1;
          w_state_nxt = TRANSMIT;
        end
      end
      TRANSMIT: begin
        db_estado = 4'h1;
        ocupado   = 1'b1;
        if (w_tick_end && w_last_bit) w_state_nxt = DONE;
      end
      DONE: begin
        db_estado   = 4'h2;
        pronto      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        // Unreachable encoding: flag it on the debug port and recover.
        db_estado   = 4'hF;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: tick/bit counters, shift register and registered line.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_saida <= 1'b1;
    end else if (w_load) begin
      // Start bit appears on the line the cycle after the request.
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= w_frame;
      r_saida <= w_frame[0];
    end else if (r_state == TRANSMIT) begin
      if (w_tick_end) begin
        r_tick <= '0;
        if (w_last_bit) begin
          r_bit   <= '0;
          r_saida <= 1'b1;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_shift <= {1'b1, r_shift[9:1]};
          r_saida <= r_shift[1];
        end
      end else begin
        r_tick <= r_tick + TW'(1);
      end
    end else begin
      r_saida <= 1'b1;
    end
  end

  assign saida_serial = r_saida;

endmodule

// File: doc/tx_serial_7e1.md
TX_SERIAL_7E1 -- requirements
Module: tx_serial_7e1

Interface
- REQ-001 SHALL have parameter M, default 434, meaning clock cycles per bit (50 MHz / 115200 baud); legal range 2..8191.
- REQ-002 SHALL have port clock, input, 1 bit, the single system clock; all state updates on its rising edge.
- REQ-003 SHALL have port reset, input, 1 bit; reset is synchronous and active-low.
- REQ-004 SHALL have port partida, input, 1 bit, start request, sampled only in IDLE.
- REQ-005 SHALL have port dados_ascii, input, 7 bits, character to send, captured on accepted partida.
- REQ-006 SHALL have port saida_serial, output, 1 bit, registered serial line, idle high.
- REQ-007 SHALL have port ocupado, output, 1 bit, high while a frame is in progress (TRANSMIT).
- REQ-008 SHALL have port pronto, output, 1 bit, one-clock pulse after the stop bit completes.
- REQ-009 SHALL have port db_estado, output, 4 bits, debug state code.

Function
- REQ-010 SHALL transmit 7E1 frames: start bit 0, dados_ascii[0]..[6] LSB first, even parity bit, stop bit 1 (10 bits).
- REQ-011 SHALL compute parity as XOR of the 7 captured bits, so total count of ones in data plus parity is even.
- REQ-012 SHALL implement FSM states IDLE (db_estado 0x0), TRANSMIT (0x1), DONE (0x2).
- REQ-013 IDLE: saida_serial=1, ocupado=0, pronto=0; partida=1 at an edge -> capture data into a 10-bit shift register, zero tick and bit counters, enter TRANSMIT.
- REQ-014 SHALL drive saida_serial=0 (start bit) starting the cycle after partida is sampled; latency exactly 1 clock.
- REQ-015 TRANSMIT: each bit SHALL be held exactly M clocks; the tick counter counts 0..M-1, and on M-1 the register shifts and the bit counter increments.
- REQ-016 After the 10th bit (stop) has been held M clocks, SHALL enter DONE; the frame occupies exactly 10*M cycles with ocupado=1.
- REQ-017 DONE: pronto=1, ocupado=0, saida_serial=1 for exactly 1 clock, then IDLE unconditionally.
- REQ-018 partida SHALL be ignored in TRANSMIT and DONE; changes to dados_ascii after capture SHALL NOT affect the frame in flight.
- REQ-019 Back-to-back: partida held high SHALL start the next frame from the IDLE cycle following DONE, giving exactly 2 idle-high cycles (DONE plus IDLE) between stop bit end and the next start bit.
- REQ-020 Unused state encodings SHALL return to IDLE on the next clock, with db_estado=0xF while in them.
- REQ-021 saida_serial SHALL come directly from a flip-flop, with no combinational path from any input.

Reset
- REQ-022 reset=0 at a rising edge SHALL force IDLE, saida_serial=1, ocupado=0, pronto=0, db_estado=0x0, and clear both counters and the shift register.
- REQ-023 Reset asserted mid-frame SHALL abort the frame; the line goes high the cycle after the reset edge and no pronto pulse is issued.
- REQ-024 reset is synchronous only; no output SHALL change between clock edges.

Verification (M=4)
- REQ-025 Send 'A' (0x41): pulse partida 1 cycle -> saida_serial sequence 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles, ocupado high 40 cycles, pronto high 1 cycle right after.
- REQ-026 Send 0x07: line 0,1,1,1,0,0,0,0,1,1 (parity 1); a receiver loop-back at 4 clocks/bit yields 0x07 with parity OK.
- REQ-027 Pulse partida with 0x55, then pulse partida with 0x2A at cycle 10 -> the 0x55 frame is unaltered and the second request is dropped, so only one pronto pulse occurs.
- REQ-028 Assert reset=0 during data bit 3 -> next cycle saida_serial=1, ocupado=0, db_estado=0x0; no pronto pulse; a new partida then sends a clean frame.
- REQ-029 Hold partida=1 across two frames -> pronto pulse, one IDLE-high cycle, then a start bit; total 2 high cycles between frames.
- REQ-030 Change dados_ascii every cycle during TRANSMIT -> transmitted bits match the value captured at start.
